// File: rtl/tour_pkg.sv
// Shared definitions for the tour replay path: command opcodes, headings,
// FSM state type, tour length and the knight-move bit ordering.
package tour_pkg;

  localparam int unsigned NUM_MOVES = 24;
  localparam int unsigned IDX_W     = 5;
  localparam int unsigned MOVE_W    = 8;
  localparam int unsigned CMD_W     = 16;
  localparam int unsigned OP_W      = 4;
  localparam int unsigned HEAD_W    = 8;
  localparam int unsigned SQ_W      = 4;
  localparam int unsigned RESP_W    = 8;

  localparam logic [OP_W-1:0] OP_MOVE    = 4'b0010;
  localparam logic [OP_W-1:0] OP_MOVE_FF = 4'b0011;

  localparam logic [HEAD_W-1:0] HDG_N = 8'h00;
  localparam logic [HEAD_W-1:0] HDG_W = 8'h3F;
  localparam logic [HEAD_W-1:0] HDG_S = 8'h7F;
  localparam logic [HEAD_W-1:0] HDG_E = 8'hBF;

  localparam logic [RESP_W-1:0] RESP_DONE = 8'hA5;
  localparam logic [RESP_W-1:0] RESP_BUSY = 8'h5A;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VERT,
    ST_VERT_WAIT,
    ST_HORZ,
    ST_HORZ_WAIT
  } tour_state_e;

  // Command word as seen by the command processor
  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [HEAD_W-1:0] hdg;
    logic [SQ_W-1:0]   sq;
  } tour_cmd_t;

  // Horizontal displacement for one-hot move bit b
  function automatic logic signed [2:0] move_dx(input logic [2:0] b);
    case (b)
      3'd0:    return 3'sd2;
      3'd1:    return 3'sd1;
      3'd2:    return -3'sd1;
      3'd3:    return -3'sd2;
      3'd4:    return -3'sd2;
      3'd5:    return -3'sd1;
      3'd6:    return 3'sd1;
      default: return 3'sd2;
    endcase
  endfunction

  // Vertical displacement for one-hot move bit b
  function automatic logic signed [2:0] move_dy(input logic [2:0] b);
    case (b)
      3'd0:    return 3'sd1;
      3'd1:    return 3'sd2;
      3'd2:    return 3'sd2;
      3'd3:    return 3'sd1;
      3'd4:    return -3'sd1;
      3'd5:    return -3'sd2;
      3'd6:    return -3'sd2;
      default: return -3'sd1;
    endcase
  endfunction

  // Magnitude of a displacement as a square count
  function automatic logic [SQ_W-1:0] abs_sq(input logic signed [2:0] v);
    return v[2] ? SQ_W'(-v) : SQ_W'(v);
  endfunction

endpackage

// File: rtl/tour_cmd_move_decode.sv
// Combinational decode of a one-hot knight move into vertical and
// horizontal leg headings/square counts, plus a one-hot valid flag.
module tour_cmd_move_decode
  import tour_pkg::*;
(
  input  logic [MOVE_W-1:0] move,
  output logic [HEAD_W-1:0] vert_hdg,
  output logic [SQ_W-1:0]   vert_sq,
  output logic [HEAD_W-1:0] horz_hdg,
  output logic [SQ_W-1:0]   horz_sq,
  output logic              valid
);

  logic [2:0]        bit_idx;
  logic signed [2:0] dx;
  logic signed [2:0] dy;

  // Locate the set bit and map it to the two legs
  always_comb begin
    bit_idx = 3'd0;
    for (int i = MOVE_W - 1; i >= 0; i--) begin
      if (move[i]) bit_idx = 3'(i);
    end
    valid    = (move != '0) && ((move & (move - MOVE_W'(1))) == '0);
    dx       = move_dx(bit_idx);
    dy       = move_dy(bit_idx);
    vert_hdg = dy[2] ? HDG_S : HDG_N;
    vert_sq  = abs_sq(dy);
    horz_hdg = dx[2] ? HDG_W : HDG_E;
    horz_sq  = abs_sq(dx);
  end

endmodule

// File: rtl/tour_cmd.sv
// Tour command generator: replays the solver's stored moves as pairs of
// vertical/horizontal robot commands, otherwise passes UART commands through.
// Optional macro TOUR_CMD_FANFARE_EN: horizontal leg uses the fanfare opcode.
module tour_cmd
  import tour_pkg::*;
#(
  parameter int unsigned NUM_MOVES_P = NUM_MOVES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_tour,
  input  logic [MOVE_W-1:0] move,
  output logic [IDX_W-1:0]  mv_indx,
  input  logic [CMD_W-1:0]  cmd_UART,
  input  logic              cmd_rdy_UART,
  input  logic              clr_cmd_rdy,
  input  logic              send_resp,
  output logic [CMD_W-1:0]  cmd,
  output logic              cmd_rdy,
  output logic [RESP_W-1:0] resp
);

`ifdef TOUR_CMD_FANFARE_EN
  localparam logic [OP_W-1:0] HORZ_OP = OP_MOVE_FF;
`else
  localparam logic [OP_W-1:0] HORZ_OP = OP_MOVE;
`endif

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MOVES_P - 1);

  tour_state_e       state;
  tour_state_e       nxt_state;
  logic [IDX_W-1:0]  nxt_indx;
  logic [HEAD_W-1:0] vert_hdg;
  logic [SQ_W-1:0]   vert_sq;
  logic [HEAD_W-1:0] horz_hdg;
  logic [SQ_W-1:0]   horz_sq;
  logic              mv_valid;
  tour_cmd_t         vert_cmd;
  tour_cmd_t         horz_cmd;
  logic              last_move;

  tour_cmd_move_decode u_decode (
    .move     (move),
    .vert_hdg (vert_hdg),
    .vert_sq  (vert_sq),
    .horz_hdg (horz_hdg),
    .horz_sq  (horz_sq),
    .valid    (mv_valid)
  );

  // Build leg commands; a malformed move degrades to zero-length legs
  always_comb begin
    vert_cmd.op  = OP_MOVE;
    vert_cmd.hdg = mv_valid ? vert_hdg : HDG_N;
    vert_cmd.sq  = mv_valid ? vert_sq : '0;
    horz_cmd.op  = HORZ_OP;
    horz_cmd.hdg = mv_valid ? horz_hdg : HDG_N;
    horz_cmd.sq  = mv_valid ? horz_sq : '0;
    last_move    = (mv_indx == LAST_IDX);
  end

  // State and move index registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      mv_indx <= '0;
    end else begin
      state   <= nxt_state;
      mv_indx <= nxt_indx;
    end
  end

  // Next-state, index update and command mux
  always_comb begin
    nxt_state = state;
    nxt_indx  = mv_indx;
    cmd       = cmd_UART;
    cmd_rdy   = 1'b0;
    resp      = RESP_BUSY;
    case (state)
      ST_IDLE: begin
        cmd     = cmd_UART;
        cmd_rdy = cmd_rdy_UART;
        resp    = RESP_DONE;
        if (start_tour) begin
          nxt_indx  = '0;
          nxt_state = ST_VERT;
        end
      end
      ST_VERT: begin
        cmd     = vert_cmd;
        cmd_rdy = 1'b1;
        if (clr_cmd_rdy) nxt_state = ST_VERT_WAIT;
      end
      ST_VERT_WAIT: begin
        cmd = vert_cmd;
        if (send_resp) nxt_state = ST_HORZ;
      end
      ST_HORZ: begin
        cmd     = horz_cmd;
        cmd_rdy = 1'b1;
        if (clr_cmd_rdy) nxt_state = ST_HORZ_WAIT;
      end
      ST_HORZ_WAIT: begin
        cmd = horz_cmd;
        if (last_move) resp = RESP_DONE;
        if (send_resp) begin
          if (last_move) begin
            nxt_indx  = '0;
            nxt_state = ST_IDLE;
          end else begin
            nxt_indx  = mv_indx + IDX_W'(1);
            nxt_state = ST_VERT;
          end
        end
      end
      default: nxt_state = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_tour_cmd.sv
// Randomized self-checking bench for tour_cmd with a scripted solver and a
// transaction-level command model derived from the knight-move table.
module tb_tour_cmd;

`ifdef TOUR_CMD_FANFARE_EN
  localparam logic [3:0] HOP = 4'h3;
`else
  localparam logic [3:0] HOP = 4'h2;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_tour = 1'b0;
  logic [7:0]  move;
  logic [4:0]  mv_indx;
  logic [15:0] cmd_UART = 16'h0;
  logic        cmd_rdy_UART = 1'b0;
  logic        clr_cmd_rdy = 1'b0;
  logic        send_resp = 1'b0;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic [7:0]  resp;

  logic [7:0]  sol [32];
  int          total = 0;
  int          bad = 0;
  bit          tour_on = 1'b0;
  bit          uart_rand = 1'b0;
  int          exp_idx = 0;

  tour_cmd dut (
    .clk          (clk),
    .rst          (rst),
    .start_tour   (start_tour),
    .move         (move),
    .mv_indx      (mv_indx),
    .cmd_UART     (cmd_UART),
    .cmd_rdy_UART (cmd_rdy_UART),
    .clr_cmd_rdy  (clr_cmd_rdy),
    .send_resp    (send_resp),
    .cmd          (cmd),
    .cmd_rdy      (cmd_rdy),
    .resp         (resp)
  );

  always #5 clk = ~clk;

  // Solver model: stored move for the requested index
  always_comb move = sol[mv_indx];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Expected command for one leg of a stored move
  function automatic logic [15:0] model_cmd(input logic [7:0] mv, input bit horz);
    int dx_t [8];
    int dy_t [8];
    int n;
    int b;
    int dx;
    int dy;
    dx_t = '{2, 1, -1, -2, -2, -1, 1, 2};
    dy_t = '{1, 2, 2, 1, -1, -2, -2, -1};
    n = 0;
    b = 0;
    for (int i = 0; i < 8; i++) begin
      if (mv[i]) begin
        n++;
        b = i;
      end
    end
    if (n != 1) return horz ? {HOP, 8'h00, 4'h0} : 16'h2000;
    dx = dx_t[b];
    dy = dy_t[b];
    if (horz) return {HOP, (dx > 0) ? 8'hBF : 8'h3F, 4'((dx < 0) ? -dx : dx)};
    return {4'h2, (dy > 0) ? 8'h00 : 8'h7F, 4'((dy < 0) ? -dy : dy)};
  endfunction

  function automatic logic [7:0] rand_move();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 8'h00;
    if (r == 1) return 8'($urandom);
    return 8'h01 << $urandom_range(0, 7);
  endfunction

  // Random UART traffic while enabled
  always @(posedge clk) begin
    #1;
    if (uart_rand) begin
      cmd_UART     = 16'($urandom);
      cmd_rdy_UART = 1'($urandom_range(0, 1));
    end
  end

  // Per-cycle compare: passthrough when idle, index tracking during a tour
  always @(negedge clk) begin
    if (!rst) begin
      if (!tour_on) begin
        chk("idle_cmd", 32'(cmd), 32'(cmd_UART));
        chk("idle_rdy", 32'(cmd_rdy), 32'(cmd_rdy_UART));
        chk("idle_resp", 32'(resp), 32'h0A5);
        chk("idle_indx", 32'(mv_indx), 32'd0);
      end else begin
        chk("tour_indx", 32'(mv_indx), 32'(exp_idx));
      end
    end
  end

  // Act as the command processor for one tour; abort_k >= 0 resets mid-tour
  task automatic run_tour(input int abort_k, input bit use_lit);
    logic [15:0] lit [4];
    lit[0] = 16'h2001;
    lit[1] = {HOP, 8'hBF, 4'h2};
    lit[2] = 16'h27F2;
    lit[3] = 16'h23F1;
    @(posedge clk); #1 start_tour = 1'b1;
    @(posedge clk); #1 start_tour = 1'b0;
    tour_on = 1'b1;
    exp_idx = 0;
    for (int k = 0; k < 48; k++) begin
      int m;
      bit h;
      bit seen;
      logic [15:0] e;
      m = k / 2;
      h = (k % 2) == 1;
      e = model_cmd(sol[m], h);
      seen = 1'b0;
      for (int w = 0; w < 8; w++) begin
        @(negedge clk);
        if (cmd_rdy === 1'b1) begin
          seen = 1'b1;
          break;
        end
      end
      if (!seen) begin
        total++;
        bad++;
        $display("FAIL rdy_timeout: cmd %0d cmd_rdy=%0b required 1", k, cmd_rdy);
        tour_on = 1'b0;
        return;
      end
      chk("tour_cmd", 32'(cmd), 32'(e));
      if (use_lit && k < 4) chk("lit_cmd", 32'(cmd), 32'(lit[k]));
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        chk("hold_rdy", 32'(cmd_rdy), 32'd1);
        chk("hold_cmd", 32'(cmd), 32'(e));
      end
      clr_cmd_rdy = 1'b1;
      send_resp   = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      clr_cmd_rdy = 1'b0;
      send_resp   = 1'b0;
      if (k == abort_k) begin
        chk("abort_indx", 32'(mv_indx), 32'(abort_k / 2));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        tour_on = 1'b0;
        exp_idx = 0;
        return;
      end
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        chk("wait_rdy", 32'(cmd_rdy), 32'd0);
        if (h) start_tour = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      start_tour = 1'b0;
      send_resp  = 1'b1;
      chk("wait_rdy", 32'(cmd_rdy), 32'd0);
      chk("resp", 32'(resp), (k == 47) ? 32'h0A5 : 32'h05A);
      @(posedge clk); #1;
      send_resp = 1'b0;
      if (h) exp_idx = (k == 47) ? 0 : exp_idx + 1;
      if (k == 47) tour_on = 1'b0;
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) sol[i] = rand_move();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_indx", 32'(mv_indx), 32'd0);
    chk("rst_resp", 32'(resp), 32'h0A5);
    chk("rst_rdy", 32'(cmd_rdy), 32'd0);

    @(posedge clk); #1;
    cmd_UART     = 16'h2403;
    cmd_rdy_UART = 1'b1;
    @(negedge clk);
    chk("lit_idle_cmd", 32'(cmd), 32'h2403);
    chk("lit_idle_rdy", 32'(cmd_rdy), 32'd1);
    chk("lit_idle_resp", 32'(resp), 32'h0A5);
    @(posedge clk); #1 cmd_rdy_UART = 1'b0;

    sol[0] = 8'h01;
    sol[1] = 8'h20;
    sol[2] = 8'h00;
    run_tour(-1, 1'b1);
    @(negedge clk);
    chk("lit_end_indx", 32'(mv_indx), 32'd0);

    uart_rand = 1'b1;
    repeat (5) @(posedge clk);
    for (int i = 0; i < 32; i++) sol[i] = rand_move();
    run_tour(-1, 1'b0);

    for (int i = 0; i < 32; i++) sol[i] = rand_move();
    run_tour(14, 1'b0);
    repeat (10) @(posedge clk);

    for (int i = 0; i < 32; i++) sol[i] = rand_move();
    run_tour(-1, 1'b0);
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
